led_chaser_pwm: RTL
===================

// Module: led_chaser_pwm
// PURPOSE
//   Parametrised LED pattern engine for Pmod LED boards. A built-in prescaler produces step ticks.
//   On each tick the engine advances one of four patterns (shift, bounce, fill, all-on) across NUM_LEDS outputs.
//   Optional PWM fade gives a dimming trail behind the lit LED. Sits between top-level pins and the board clock.
// PARAMETERS
//   NUM_LEDS  8        number of LED outputs; legal range >= 2
//   TICK_DIV  8000000  clk cycles per pattern step; legal range >= 2
//   PWM_BITS  4        brightness resolution, fade build only; legal range >= 2
// PORTS
//   clk         in   1         system clock, all logic on posedge
//   rst         in   1         synchronous reset, active-high
//   run         in   1         1 = animate; 0 = hold all LEDs on and re-arm the pattern
//   mode        in   2         0 SHIFT, 1 BOUNCE, 2 FILL, 3 ALL_ON
//   leds        out  NUM_LEDS  LED drive, bit0 = first LED, registered
//   step_pulse  out  1         one-cycle strobe on each pattern step, registered
// BEHAVIOUR
// - One clock, clk. Reset is synchronous, active-high (rst).
// - Reset state: leds=0, step_pulse=0, prescaler=0, pos=0, dir=UP, fill=0, mode_q=0. All brightness regs=0.
// - Prescaler: counts 0..TICK_DIV-1 and wraps. step_pulse=1 in the cycle after count==TICK_DIV-1.
//   The pattern advances in that same cycle and leds update together with step_pulse.
// - Pattern state advances only on step. Per-mode behaviour:
//   SHIFT: pos = (pos==NUM_LEDS-1) ? 0 : pos+1; leds = 1<<pos. Sequence: 0x01, 0x02, ... 0x80, 0x01.
//   BOUNCE: pos moves by dir. At pos==NUM_LEDS-1, dir becomes DOWN; at pos==0, dir becomes UP.
//     The endpoint LED is shown once, e.g. 0x40, 0x80, 0x40.
//   FILL: fill counts 0..NUM_LEDS, then returns to 0; leds = (1<<fill)-1. Sequence: 0x00, 0x01, 0x03, ... 0xFF, 0x00.
//   ALL_ON: leds = all ones; pos, dir and fill are held.
// - The first step after reset or after re-arm shows pos=0 (SHIFT/BOUNCE) or fill=1 (FILL).
// - Mode change: mode is sampled on each step. If mode != mode_q, the pattern re-arms to pos=0, dir=UP, fill=0
//   and that step displays the new mode's first frame. mode_q then updates.
// - run=0: next cycle leds = all ones. Prescaler is held at 0, step_pulse=0, and the pattern re-arms.
//   On run 0->1, the first step occurs TICK_DIV cycles later.
// - rst has priority over run. rst asserted mid-step clears everything in the following cycle.
// - Widths: the prescaler is $clog2(TICK_DIV) bits, pos is $clog2(NUM_LEDS) bits, fill is $clog2(NUM_LEDS+1) bits.
//   No arithmetic overflow is reachable.
// CONFIGURATION
// - LED_CHASER_FADE_EN defined: each LED has a PWM_BITS brightness reg and a free-running PWM_BITS pwm counter.
//   A pattern bit at 1 sets its brightness to max (2^PWM_BITS-1) on each step.
//   Every other brightness decrements by 1 on each step, saturating at 0.
//   leds[i] = run ? (bright[i] > pwm_cnt) : 1. Max brightness gives duty (2^P-1)/2^P.
//   ALL_ON and run=0 force full on with no PWM.
// - Macro undefined: no brightness or pwm logic; leds = pattern directly; PWM_BITS has no effect.
// STRUCTURE
// - Package led_chaser_pkg holds:
//   mode_e enum (MODE_SHIFT=2'd0, MODE_BOUNCE, MODE_FILL, MODE_ALL_ON) and dir_e (DIR_UP, DIR_DOWN).
// - Sub-module led_tick_gen #(TICK_DIV): ports clk, rst, clr, tick. It is the prescaler; clr is driven by !run.
// - Pattern FSM and output/PWM register stage live in led_chaser_pwm.
// TESTING (NUM_LEDS=8, TICK_DIV=4, PWM_BITS=4 unless stated)
// - Reset: hold rst for 3 cycles -> leds=0x00, step_pulse=0; after release the first step_pulse occurs 4 cycles later.
// - SHIFT, run=1: leds steps 0x01, 0x02, ... 0x80, 0x01, with a step every 4 clk. step_pulse is high exactly 1 cycle per step.
// - BOUNCE: observe 0x01 ... 0x80, 0x40 ... 0x01, 0x02. There are no repeated endpoint frames.
// - FILL: observe 0x01, 0x03, ... 0xFF, 0x00, 0x01. Switching to SHIFT mid-fill shows 0x01 on the next step.
// - run=0 at leds=0x08 -> 0xFF on the next cycle and step_pulse stays 0. run=1 -> 0x01 after 4 cycles.
//   rst=1 together with run=0 -> leds=0x00.
// - FADE_EN build, SHIFT: after 3 steps, LED2 has duty 15/16, LED1 14/16, LED0 13/16.
//   Measure each over 16 cycles; all other LEDs stay dark.

Source files
------------

// File: rtl/led_chaser_pwm_pkg.sv
// Shared types for the LED chaser: pattern mode and bounce direction.
package led_chaser_pkg;
    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_ALL_ON = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;
endpackage

// File: rtl/led_chaser_pwm_if.sv
// Control/status bundle between board-level logic (master) and the LED chaser (slave).
interface led_chaser_pwm_if #(parameter int NUM_LEDS = 8);
    import led_chaser_pkg::*;

    logic                run;
    mode_e               mode;
    logic [NUM_LEDS-1:0] leds;
    logic                step_pulse;

    modport master (output run, output mode, input leds, input step_pulse);
    modport slave  (input run, input mode, output leds, output step_pulse);
endinterface

// File: rtl/led_chaser_pwm_tick.sv
// Step prescaler: counts 0..TICK_DIV-1, tick is high while the count sits on its last value.
module led_tick_gen #(
    parameter int TICK_DIV = 8000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = !clr && w_last;

    always_ff @(posedge clk) begin
        if (rst || clr)  r_cnt <= '0;
        else if (w_last) r_cnt <= '0;
        else             r_cnt <= r_cnt + ONE;
    end
endmodule

// File: rtl/led_chaser_pwm.sv
// LED pattern engine (shift/bounce/fill/all-on) stepped by a prescaler.
// Define LED_CHASER_FADE_EN for the PWM dimming trail behind lit LEDs.
module led_chaser_pwm
    import led_chaser_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int TICK_DIV = 8000000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    led_chaser_pwm_if.slave     bus
);
    localparam int PW = $clog2(NUM_LEDS);
    localparam int FW = $clog2(NUM_LEDS + 1);
    localparam logic [PW-1:0]       POS_LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0]       POS_ONE  = PW'(1);
    localparam logic [FW-1:0]       FILL_MAX = FW'(NUM_LEDS);
    localparam logic [FW-1:0]       FILL_ONE = FW'(1);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

    if (NUM_LEDS < 2) begin : g_chk_leds
        $error("NUM_LEDS must be >= 2");
    end
    if (TICK_DIV < 2) begin : g_chk_div
        $error("TICK_DIV must be >= 2");
    end
    if (PWM_BITS < 2) begin : g_chk_pwm
        $error("PWM_BITS must be >= 2");
    end

    logic                r_step_pulse;
    logic [NUM_LEDS-1:0] r_leds;
    logic [PW-1:0]       r_pos;
    dir_e                r_dir;
    logic [FW-1:0]       r_fill;
    mode_e               r_mode_q;

    logic                w_tick;
    logic                w_rearm;
    logic [PW-1:0]       w_pos_base, w_pos_nxt;
    dir_e                w_dir_base, w_dir_nxt;
    logic [FW-1:0]       w_fill_base, w_fill_nxt;
    logic [NUM_LEDS-1:0] w_frame;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!bus.run),
        .tick (w_tick)
    );

    // A mode change re-arms, so the step that sees it shows the new mode's first frame.
    assign w_rearm     = (bus.mode != r_mode_q);
    assign w_pos_base  = w_rearm ? '0 : r_pos;
    assign w_dir_base  = w_rearm ? DIR_UP : r_dir;
    assign w_fill_base = w_rearm ? '0 : r_fill;

    always_comb begin
        w_pos_nxt  = w_pos_base;
        w_dir_nxt  = w_dir_base;
        w_fill_nxt = w_fill_base;
        w_frame    = '0;
        case (bus.mode)
            MODE_SHIFT: begin
                w_frame   = LED_ONE << w_pos_base;
                w_pos_nxt = (w_pos_base == POS_LAST) ? '0 : w_pos_base + POS_ONE;
            end
            MODE_BOUNCE: begin
                w_frame = LED_ONE << w_pos_base;
                if (w_pos_base == POS_LAST) w_dir_nxt = DIR_DOWN;
                else if (w_pos_base == '0)  w_dir_nxt = DIR_UP;
                w_pos_nxt = (w_dir_nxt == DIR_UP) ? w_pos_base + POS_ONE : w_pos_base - POS_ONE;
            end
            MODE_FILL: begin
                w_fill_nxt = (w_fill_base == FILL_MAX) ? '0 : w_fill_base + FILL_ONE;
                w_frame    = (LED_ONE << w_fill_nxt) - LED_ONE;
            end
            default: w_frame = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_pulse <= 1'b0;
            r_pos        <= '0;
            r_dir        <= DIR_UP;
            r_fill       <= '0;
            r_mode_q     <= MODE_SHIFT;
        end else if (!bus.run) begin
            r_step_pulse <= 1'b0;
            r_pos        <= '0;
            r_dir        <= DIR_UP;
            r_fill       <= '0;
        end else begin
            r_step_pulse <= w_tick;
            if (w_tick) begin
                r_pos    <= w_pos_nxt;
                r_dir    <= w_dir_nxt;
                r_fill   <= w_fill_nxt;
                r_mode_q <= bus.mode;
            end
        end
    end

`ifdef LED_CHASER_FADE_EN
    logic [NUM_LEDS-1:0][PWM_BITS-1:0] r_bright, w_bright_nxt;
    logic [PWM_BITS-1:0]               r_pwm;
    logic [NUM_LEDS-1:0]               w_pwm_leds;
    logic                              w_full_on;

    // Compare against the upcoming brightness so the output changes in the step_pulse cycle.
    always_comb begin
        w_bright_nxt = r_bright;
        w_pwm_leds   = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_tick) begin
                if (w_frame[i])            w_bright_nxt[i] = '1;
                else if (r_bright[i] != '0) w_bright_nxt[i] = r_bright[i] - PWM_BITS'(1);
            end
            w_pwm_leds[i] = (w_bright_nxt[i] > r_pwm);
        end
    end

    assign w_full_on = !bus.run || ((w_tick ? bus.mode : r_mode_q) == MODE_ALL_ON);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright <= '0;
            r_pwm    <= '0;
            r_leds   <= '0;
        end else begin
            r_bright <= w_bright_nxt;
            r_pwm    <= r_pwm + PWM_BITS'(1);
            r_leds   <= w_full_on ? '1 : w_pwm_leds;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)           r_leds <= '0;
        else if (!bus.run) r_leds <= '1;
        else if (w_tick)   r_leds <= w_frame;
    end
`endif

    assign bus.leds       = r_leds;
    assign bus.step_pulse = r_step_pulse;
endmodule
